// File: rtl/i2s_intr_ctrl_axil_if.sv
// AXI4-Lite slave bus bundle for the I2S interrupt controller.
// The slave modport is the register block side; the master modport is the CPU/test side.
interface i2s_intr_ctrl_axil_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/i2s_intr_ctrl_axil.sv
// AXI4-Lite interrupt controller: per-source edge latch, enable mask, W1C ack, global enable, one irq line.
// Register access completes in 2 cycles per channel; irq follows ISR/IER/GIE one cycle later (registered).
// B/R responses hold until BREADY/RREADY; I2S_INTR_LEVEL_MODE_EN adds the IMR level-mode register at 0x14.
module i2s_intr_ctrl_axil #(
    parameter int C_NUM_OF_INTR      = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter bit C_IRQ_ACTIVE_HIGH  = 1'b1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [C_NUM_OF_INTR-1:0] intr_src,
    output logic                     irq,
    i2s_intr_ctrl_axil_if.slave      s_axi
);
    localparam int N = C_NUM_OF_INTR;

    logic          aw_rdy, b_vld, ar_rdy, r_vld;
    logic [31:0]   r_dat;
    logic          gie;
    logic [N-1:0]  ier, isr, src_q;
    logic          irq_r;
    logic [31:0]   wmask, rd_mux;
    logic [N-1:0]  edge_v, set_v, clr_v;
    logic [2:0]    wsel, rsel;
    logic          wr_hs, rd_hs;
    logic          unused_ok;

    assign s_axi.S_AXI_AWREADY = aw_rdy;
    assign s_axi.S_AXI_WREADY  = aw_rdy;
    assign s_axi.S_AXI_BVALID  = b_vld;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = ar_rdy;
    assign s_axi.S_AXI_RVALID  = r_vld;
    assign s_axi.S_AXI_RDATA   = r_dat;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign wsel  = s_axi.S_AXI_AWADDR[4:2];
    assign rsel  = s_axi.S_AXI_ARADDR[4:2];
    assign wr_hs = aw_rdy & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_hs = ar_rdy & s_axi.S_AXI_ARVALID;
    assign wmask = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
                    {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};

    assign edge_v = intr_src & ~src_q;
    assign clr_v  = (wr_hs && wsel == 3'd3) ? (s_axi.S_AXI_WDATA[N-1:0] & wmask[N-1:0]) : '0;

`ifdef I2S_INTR_LEVEL_MODE_EN
    logic [N-1:0] imr;
    // A level source re-sets its bit every cycle, so an ack while it is still high is overridden.
    assign set_v = edge_v | (imr & intr_src);
`else
    assign set_v = edge_v;
`endif

    always_comb begin
        rd_mux = '0;
        case (rsel)
            3'd0: rd_mux = {31'd0, gie};
            3'd1: rd_mux = 32'(ier);
            3'd2: rd_mux = 32'(isr);
            3'd4: rd_mux = 32'(isr & ier);
`ifdef I2S_INTR_LEVEL_MODE_EN
            3'd5: rd_mux = 32'(imr);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_dat  <= '0;
            gie    <= 1'b0;
            ier    <= '0;
            isr    <= '0;
            src_q  <= '1;
            irq_r  <= 1'b0;
`ifdef I2S_INTR_LEVEL_MODE_EN
            imr    <= '0;
`endif
        end else begin
            src_q <= intr_src;
            isr   <= (isr & ~clr_v) | set_v;
            irq_r <= gie & |(isr & ier);

            if (b_vld && s_axi.S_AXI_BREADY) b_vld <= 1'b0;
            if (wr_hs) begin
                aw_rdy <= 1'b0;
                b_vld  <= 1'b1;
                case (wsel)
                    3'd0: if (wmask[0]) gie <= s_axi.S_AXI_WDATA[0];
                    3'd1: ier <= (ier & ~wmask[N-1:0]) | (s_axi.S_AXI_WDATA[N-1:0] & wmask[N-1:0]);
`ifdef I2S_INTR_LEVEL_MODE_EN
                    3'd5: imr <= (imr & ~wmask[N-1:0]) | (s_axi.S_AXI_WDATA[N-1:0] & wmask[N-1:0]);
`endif
                    default: ;
                endcase
            end else if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !b_vld && !aw_rdy) begin
                aw_rdy <= 1'b1;
            end

            if (r_vld && s_axi.S_AXI_RREADY) r_vld <= 1'b0;
            if (rd_hs) begin
                ar_rdy <= 1'b0;
                r_vld  <= 1'b1;
                r_dat  <= rd_mux;
            end else if (s_axi.S_AXI_ARVALID && !r_vld && !ar_rdy) begin
                ar_rdy <= 1'b1;
            end
        end
    end

    assign irq = C_IRQ_ACTIVE_HIGH ? irq_r : ~irq_r;

    // Byte-lane offset bits and unmapped data/strobe lanes carry no information here.
    assign unused_ok = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], s_axi.S_AXI_WDATA, wmask};
endmodule
